// File: rtl/core_mailbox_pkg.sv
// core_mailbox_pkg: shared definitions for the inter-core mailbox.
//   - Register select offsets (addr[3:2]) for DATA, STATUS and CTRL.
//   - STATUS and CTRL bit positions.
//   - status_word(): packs the STATUS register from its fields.
package core_mailbox_pkg;

  localparam logic [1:0] MBOX_DATA   = 2'd0;
  localparam logic [1:0] MBOX_STATUS = 2'd1;
  localparam logic [1:0] MBOX_CTRL   = 2'd2;

  localparam int unsigned STAT_NOT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT      = 1;
  localparam int unsigned STAT_OVF_BIT       = 2;
  localparam int unsigned STAT_COUNT_LSB     = 8;

  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_OVF_CLR_BIT = 1;

  function automatic logic [31:0] status_word(input logic       not_empty,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [31:0] w;
    w                       = '0;
    w[STAT_NOT_EMPTY_BIT]   = not_empty;
    w[STAT_FULL_BIT]        = full;
    w[STAT_OVF_BIT]         = ovf;
    w[STAT_COUNT_LSB +: 8]  = count;
    return w;
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// mbox_fifo: circular-buffer FIFO for one mailbox direction.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   push_i, wdata_i        sender writes a word (dropped when full unless popped same cycle)
//   pop_i                  receiver consumes the head (ignored when empty)
//   flush_i                receiver empties the FIFO; wins over a same-cycle push
//   rdata_o                head word, 0 when empty
//   count_o                number of stored words
//   full_o, empty_o        occupancy flags
//   drop_o                 this cycle's push is being rejected because the FIFO is full
module mbox_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, do_push, do_pop;

  assign full  = (count_q == CW'(Depth));
  assign empty = (count_q == '0);

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop_i & ~empty & ~flush_i;
  assign do_push = push_i & (~full | pop_i) & ~flush_i;
  assign drop_o  = push_i & full & ~pop_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/core_mailbox.sv
// core_mailbox: memory-mapped message mailbox between core 0 and core 1.
// Two FIFOs: core 0 -> core 1 and core 1 -> core 0. Register window at BASE (16 bytes):
//   +0x0 DATA   store pushes outbound, load reads inbound head (pops when reN=1)
//   +0x4 STATUS {count[15:8], ovf[2], outbound full[1], inbound non-empty[0]}
//   +0x8 CTRL   write-only: bit0 flush inbound, bit1 clear overflow flag
//   +0xC reserved
// Ports (N = 0, 1):
//   clk, reset           clock, asynchronous active-high reset
//   weN, reN             store / load strobes
//   addrN, wdataN        bus address and store data
//   rdataN               load data (0 outside the window)
//   hitN                 address falls in the mailbox window
//   irqN                 inbound FIFO non-empty
// Build option: define CORE_MAILBOX_OVF_STICKY_EN to build sticky per-sender overflow flags.
module core_mailbox
  import core_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter logic [31:0] BASE  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we0,
  input  logic        re0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic [31:0] rdata0,
  output logic        hit0,
  output logic        irq0,
  input  logic        we1,
  input  logic        re1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata1,
  output logic        hit1,
  output logic        irq1
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]    sel0, sel1;
  logic          push0, pop0, ctrl0, flush0, clr0;
  logic          push1, pop1, ctrl1, flush1, clr1;
  logic [31:0]   head_01, head_10;
  logic [CW-1:0] count_01, count_10;
  logic          full_01, full_10, empty_01, empty_10, drop_01, drop_10;
  logic          ovf0, ovf1;
  logic [31:0]   status0, status1;

  assign hit0 = (addr0[31:4] == BASE[31:4]);
  assign hit1 = (addr1[31:4] == BASE[31:4]);
  assign sel0 = addr0[3:2];
  assign sel1 = addr1[3:2];

  assign push0  = hit0 & we0 & (sel0 == MBOX_DATA);
  assign pop0   = hit0 & re0 & (sel0 == MBOX_DATA);
  assign ctrl0  = hit0 & we0 & (sel0 == MBOX_CTRL);
  assign flush0 = ctrl0 & wdata0[CTRL_FLUSH_BIT];
  assign clr0   = ctrl0 & wdata0[CTRL_OVF_CLR_BIT];

  assign push1  = hit1 & we1 & (sel1 == MBOX_DATA);
  assign pop1   = hit1 & re1 & (sel1 == MBOX_DATA);
  assign ctrl1  = hit1 & we1 & (sel1 == MBOX_CTRL);
  assign flush1 = ctrl1 & wdata1[CTRL_FLUSH_BIT];
  assign clr1   = ctrl1 & wdata1[CTRL_OVF_CLR_BIT];

  // Core 0 -> core 1: core 0 pushes, core 1 pops and flushes.
  mbox_fifo #(
    .Depth (DEPTH)
  ) u_fifo_01 (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push0),
    .pop_i   (pop1),
    .flush_i (flush1),
    .wdata_i (wdata0),
    .rdata_o (head_01),
    .count_o (count_01),
    .full_o  (full_01),
    .empty_o (empty_01),
    .drop_o  (drop_01)
  );

  // Core 1 -> core 0.
  mbox_fifo #(
    .Depth (DEPTH)
  ) u_fifo_10 (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push1),
    .pop_i   (pop0),
    .flush_i (flush0),
    .wdata_i (wdata1),
    .rdata_o (head_10),
    .count_o (count_10),
    .full_o  (full_10),
    .empty_o (empty_10),
    .drop_o  (drop_10)
  );

`ifdef CORE_MAILBOX_OVF_STICKY_EN
  logic ovf0_q, ovf0_d, ovf1_q, ovf1_d;

  // A new overflow beats a same-cycle clear.
  assign ovf0_d = (ovf0_q & ~clr0) | drop_01;
  assign ovf1_d = (ovf1_q & ~clr1) | drop_10;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf0_q <= 1'b0;
      ovf1_q <= 1'b0;
    end else begin
      ovf0_q <= ovf0_d;
      ovf1_q <= ovf1_d;
    end
  end

  assign ovf0 = ovf0_q;
  assign ovf1 = ovf1_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{drop_01, drop_10, clr0, clr1};
  assign ovf0       = 1'b0;
  assign ovf1       = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^{addr0[1:0], addr1[1:0]};

  assign status0 = status_word(~empty_10, full_01, ovf0, 8'(count_10));
  assign status1 = status_word(~empty_01, full_10, ovf1, 8'(count_01));

  always_comb begin
    rdata0 = '0;
    if (hit0) begin
      case (sel0)
        MBOX_DATA:   rdata0 = head_10;
        MBOX_STATUS: rdata0 = status0;
        default:     rdata0 = '0;
      endcase
    end
  end

  always_comb begin
    rdata1 = '0;
    if (hit1) begin
      case (sel1)
        MBOX_DATA:   rdata1 = head_01;
        MBOX_STATUS: rdata1 = status1;
        default:     rdata1 = '0;
      endcase
    end
  end

  assign irq0 = ~empty_10;
  assign irq1 = ~empty_01;

endmodule

// File: tb/tb_core_mailbox.sv
module tb_core_mailbox;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] B     = 32'h0000_0080;
`ifdef CORE_MAILBOX_OVF_STICKY_EN
  localparam logic [31:0] OVF_BIT = 32'h4;
`else
  localparam logic [31:0] OVF_BIT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, re0, we1, re1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        hit0, hit1, irq0, irq1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_mailbox #(
    .DEPTH (DEPTH),
    .BASE  (B)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .we0    (we0),
    .re0    (re0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .rdata0 (rdata0),
    .hit0   (hit0),
    .irq0   (irq0),
    .we1    (we1),
    .re1    (re1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .rdata1 (rdata1),
    .hit1   (hit1),
    .irq1   (irq1)
  );

  typedef struct {
    logic        we0, re0;
    logic [31:0] addr0, wdata0;
    logic        we1, re1;
    logic [31:0] addr1, wdata1;
    logic [31:0] exp_rd0, exp_rd1;
    logic        exp_irq0, exp_irq1, exp_hit0, exp_hit1;
  } vec_t;

  vec_t vecs[$];

  // Reference model: one queue per direction, sticky flag per sender.
  logic [31:0] q01[$];
  logic [31:0] q10[$];
  bit          m_ovf[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w0, input logic r0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic w1, input logic r1,
                       input logic [31:0] a1, input logic [31:0] d1);
    we0 = w0; re0 = r0; addr0 = a0; wdata0 = d0;
    we1 = w1; re1 = r1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    q01.delete();
    q10.delete();
    m_ovf[0] = 0;
    m_ovf[1] = 0;
  endtask

  function automatic logic [31:0] model_rd(input int core, input logic [31:0] a);
    int          sz_in, sz_out;
    logic [31:0] head;
    if (a[31:4] != B[31:4]) return 32'h0;
    sz_in  = (core == 0) ? q10.size() : q01.size();
    sz_out = (core == 0) ? q01.size() : q10.size();
    head   = 32'h0;
    if (sz_in > 0) head = (core == 0) ? q10[0] : q01[0];
    case (a[3:2])
      2'd0: return head;
      2'd1: return {16'h0, 8'(sz_in), 5'h0, (m_ovf[core] ? OVF_BIT[2] : 1'b0),
                    sz_out == DEPTH, sz_in != 0};
      default: return 32'h0;
    endcase
  endfunction

  // dir 0: core 0 sends to core 1; dir 1: core 1 sends to core 0.
  task automatic model_dir(input int dir, input bit push, input bit pop, input bit flush,
                           input bit clr, input logic [31:0] wd);
    logic [31:0] q[$];
    int          sz;
    bit          popped, acc;
    if (dir == 0) q = q01; else q = q10;
    sz     = q.size();
    popped = 0;
    acc    = 0;
    if (flush) begin
      q.delete();
    end else begin
      if (pop && sz > 0) begin
        void'(q.pop_front());
        popped = 1;
      end
      acc = push && (sz < DEPTH || popped);
      if (acc) q.push_back(wd);
    end
    m_ovf[dir] = (m_ovf[dir] && !clr) || (push && !flush && !acc);
    if (dir == 0) q01 = q; else q10 = q;
  endtask

  task automatic model_commit();
    bit h0, h1;
    h0 = (addr0[31:4] == B[31:4]);
    h1 = (addr1[31:4] == B[31:4]);
    model_dir(0, h0 && we0 && addr0[3:2] == 2'd0, h1 && re1 && addr1[3:2] == 2'd0,
              h1 && we1 && addr1[3:2] == 2'd2 && wdata1[0],
              h0 && we0 && addr0[3:2] == 2'd2 && wdata0[1], wdata0);
    model_dir(1, h1 && we1 && addr1[3:2] == 2'd0, h0 && re0 && addr0[3:2] == 2'd0,
              h0 && we0 && addr0[3:2] == 2'd2 && wdata0[0],
              h1 && we1 && addr1[3:2] == 2'd2 && wdata1[1], wdata1);
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      4, 5:    return B + 32'h4;
      6:       return B + 32'h8;
      7:       return B + 32'hC;
      8:       return B + 32'h100 + ($urandom & 32'hC);
      default: return B;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset state, checked while reset is still held.
    addr0 = B + 32'h4;
    addr1 = B;
    #1;
    check("reset_rdata0", rdata0, 32'h0);
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_irq0", {31'h0, irq0}, 32'h0);
    check("reset_irq1", {31'h0, irq1}, 32'h0);
    check("reset_hit0", {31'h0, hit0}, 32'h1);
    reset = 1'b0;
    idle();
    step();

    // Table: basic send/receive, empty pop, off-window and reserved accesses.
    vecs.push_back('{1, 0, B,          32'h11, 0, 0, B + 4,       0, 0,      0,      0, 0, 1, 1});
    vecs.push_back('{1, 0, B,          32'h22, 0, 0, B + 4,       0, 0,      32'h101, 0, 1, 1, 1});
    vecs.push_back('{1, 0, B,          32'h33, 0, 0, B + 4,       0, 0,      32'h201, 0, 1, 1, 1});
    vecs.push_back('{0, 0, 32'h0,      0,      0, 0, B + 4,       0, 0,      32'h301, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 32'h0,      0,      0, 1, B,           0, 0,      32'h11, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 32'h0,      0,      0, 1, B,           0, 0,      32'h22, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 32'h0,      0,      0, 1, B,           0, 0,      32'h33, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 32'h0,      0,      0, 0, B + 4,       0, 0,      0,      0, 0, 0, 1});
    vecs.push_back('{0, 0, 32'h0,      0,      0, 1, B,           0, 0,      0,      0, 0, 0, 1});
    vecs.push_back('{0, 0, 32'h0,      0,      0, 1, B + 32'h100, 0, 0,      0,      0, 0, 0, 0});
    vecs.push_back('{0, 0, B + 4,      0,      0, 0, B + 4,       0, 0,      0,      0, 0, 1, 1});
    vecs.push_back('{0, 0, B + 8,      0,      1, 0, B + 32'hC, 32'hDEAD, 0, 0,      0, 0, 1, 1});
    vecs.push_back('{0, 0, B + 4,      0,      0, 0, B + 32'hC,   0, 0,      0,      0, 0, 1, 1});
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we0, vecs[i].re0, vecs[i].addr0, vecs[i].wdata0,
            vecs[i].we1, vecs[i].re1, vecs[i].addr1, vecs[i].wdata1);
      @(negedge clk);
      check($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].exp_rd0);
      check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp_rd1);
      check($sformatf("vec%0d_irq0", i), {31'h0, irq0}, {31'h0, vecs[i].exp_irq0});
      check($sformatf("vec%0d_irq1", i), {31'h0, irq1}, {31'h0, vecs[i].exp_irq1});
      check($sformatf("vec%0d_hit0", i), {31'h0, hit0}, {31'h0, vecs[i].exp_hit0});
      check($sformatf("vec%0d_hit1", i), {31'h0, hit1}, {31'h0, vecs[i].exp_hit1});
      step();
    end

    // Overflow: core 1 pushes 9 words into an 8-deep FIFO.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 0, 0, 1, 0, B, i);
      step();
    end
    drive(0, 0, B + 4, 0, 0, 0, B + 4, 0);
    @(negedge clk);
    check("ovf_full_status1", rdata1, 32'h2);
    check("ovf_status0", rdata0, 32'h0801);
    step();
    drive(0, 0, 0, 0, 1, 0, B, 9);
    step();
    drive(0, 0, 0, 0, 0, 0, B + 4, 0);
    @(negedge clk);
    check("ovf_after_drop_status1", rdata1, 32'h2 | OVF_BIT);
    step();
    drive(0, 0, 0, 0, 1, 0, B + 8, 32'h2);
    step();
    drive(0, 0, 0, 0, 0, 0, B + 4, 0);
    @(negedge clk);
    check("ovf_cleared_status1", rdata1, 32'h2);
    step();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, B, 0, 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("ovf_pop%0d", i), rdata0, i);
      step();
    end
    drive(0, 1, B, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("ovf_no_ninth", rdata0, 32'h0);
    check("ovf_irq0_low", {31'h0, irq0}, 32'h0);
    step();

    // Simultaneous push/pop at count 3 across pointer wrap.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, B, 100 + i, 0, 0, 0, 0);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, B, 103 + k, 0, 1, B, 0);
      @(negedge clk);
      check($sformatf("wrap_pop%0d", k), rdata1, 100 + k);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, B + 4, 0);
    @(negedge clk);
    check("wrap_count3", rdata1, 32'h301);
    step();
    drive(0, 0, 0, 0, 0, 0, B, 0);
    @(negedge clk);
    check("wrap_head", rdata1, 32'd120);
    step();

    // Flush by receiver beats a same-cycle push by sender.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, B, 200 + i, 0, 0, 0, 0);
      step();
    end
    drive(1, 0, B, 32'hAA, 1, 0, B + 8, 32'h1);
    step();
    drive(0, 0, B + 4, 0, 0, 0, B + 4, 0);
    @(negedge clk);
    check("flush_status1", rdata1, 32'h0);
    check("flush_irq1", {31'h0, irq1}, 32'h0);
    check("flush_status0", rdata0, 32'h0);
    step();
    drive(1, 0, B, 32'h55, 0, 1, B, 0);
    @(negedge clk);
    check("flush_load_empty", rdata1, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 1, B, 0);
    @(negedge clk);
    check("flush_next_word", rdata1, 32'h55);
    step();

    // Asynchronous reset between edges with messages queued both ways.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, B, 300 + i, 1, 0, B, 400 + i);
      step();
    end
    drive(0, 0, B, 0, 0, 0, B, 0);
    #1;
    check("areset_pre_irq0", {31'h0, irq0}, 32'h1);
    check("areset_pre_irq1", {31'h0, irq1}, 32'h1);
    check("areset_pre_rd1", rdata1, 32'd300);
    #1;
    reset = 1'b1;
    #1;
    check("areset_irq0", {31'h0, irq0}, 32'h0);
    check("areset_irq1", {31'h0, irq1}, 32'h0);
    check("areset_rd1", rdata1, 32'h0);
    step();
    reset = 1'b0;
    drive(0, 0, B + 4, 0, 0, 0, B + 4, 0);
    @(negedge clk);
    check("areset_status0", rdata0, 32'h0);
    check("areset_status1", rdata1, 32'h0);
    step();

    // Randomized traffic against the queue model, alternating fill/drain bias.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int bias;
      bias = ((c / 75) % 2 == 0) ? 75 : 25;
      we0    = ($urandom_range(0, 99) < bias);
      re0    = ($urandom_range(0, 99) >= bias);
      addr0  = rnd_addr();
      wdata0 = $urandom;
      we1    = ($urandom_range(0, 99) >= bias);
      re1    = ($urandom_range(0, 99) < bias);
      addr1  = rnd_addr();
      wdata1 = $urandom;
      @(negedge clk);
      check($sformatf("rnd%0d_rdata0", c), rdata0, model_rd(0, addr0));
      check($sformatf("rnd%0d_rdata1", c), rdata1, model_rd(1, addr1));
      check($sformatf("rnd%0d_irq0", c), {31'h0, irq0}, {31'h0, q10.size() != 0});
      check($sformatf("rnd%0d_irq1", c), {31'h0, irq1}, {31'h0, q01.size() != 0});
      check($sformatf("rnd%0d_hit1", c), {31'h0, hit1}, {31'h0, addr1[31:4] == B[31:4]});
      model_commit();
      step();
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mailbox.md
# core_mailbox

Inter-core message mailbox for the dual-core build. It is a memory-mapped responder on both cores' data-memory buses, alongside the shared data memory. It holds two independent FIFOs: core 0→core 1 and core 1→core 0. Each core writes words into its outbound FIFO and reads words from its inbound FIFO with ordinary store and load instructions, giving the cores a flow-controlled message channel that does not rely on shared-memory polling.

## Interface
Parameters:
- DEPTH, 8: entries per FIFO; power of two, 2..64.
- BASE, 32'h0000_0080: mailbox base address; 16-byte aligned.

Ports:
- clk  in  1  rising-edge clock, shared with both cores.
- reset  in  1  asynchronous, active-high; clears all state.
- we0  in  1  core 0 store strobe.
- re0  in  1  core 0 load strobe (core's mem-to-reg select).
- addr0  in  32  core 0 data address.
- wdata0  in  32  core 0 store data.
- rdata0  out  32  core 0 load data.
- hit0  out  1  core 0 address falls in the mailbox window; the top level uses it to steer rdata0 over the dmem output.
- irq0  out  1  core 0 inbound FIFO is non-empty.
- we1, re1, addr1, wdata1, rdata1, hit1, irq1: same meanings for core 1.

## Operation
- Decode: hitN = (addrN[31:4] == BASE[31:4]). Register select is addrN[3:2].
- Offset 0x0, DATA:
  - A store pushes wdataN into core N's outbound FIFO.
  - A load returns the head of the inbound FIFO. With reN=1 it pops that entry at the clock edge.
- Offset 0x4, STATUS (read-only):
  - bit0: inbound non-empty.
  - bit1: outbound full.
  - bit2: overflow (macro-dependent, see Configuration).
  - bits[15:8]: inbound count.
  - All other bits read 0.
- Offset 0x8, CTRL (write-only, reads 0):
  - bit0=1 flushes core N's inbound FIFO.
  - bit1=1 clears core N's overflow flag.
- Offset 0xC: reserved. Reads return 0; writes are ignored.
- rdataN is 0 whenever hitN=0.
- A push when the FIFO is full is dropped. Contents are unchanged.
- A pop when the FIFO is empty is ignored. DATA reads 0.
- Same FIFO, same cycle:
  - Push and pop while non-empty: count unchanged; head advances; new word is stored at the tail.
  - Push and pop while empty: the push lands and the pop is ignored, so count becomes 1.
  - Push and pop while full: the pop frees an entry and the push is accepted; count stays DEPTH.
  - Flush (by the receiver) and push (by the sender): flush wins, the push is discarded, and count becomes 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- irqN = inbound count != 0.

## Timing
- Reset values:
  - All pointers and counts are 0; overflow flags are 0.
  - irq0 = irq1 = 0; rdata0 = rdata1 = 0.
  - hitN is a pure function of addrN and is not affected by reset.
- Reads are combinational, in the same cycle as the address, matching dmem read behaviour.
- Push, pop, flush and overflow-clear commit on the posedge in the cycle the strobe is asserted.
- A word pushed at edge k is readable by the other core, and raises its irq, from edge k onward. Minimum latency from sender store to receiver load is 1 cycle.
- Reset asserted mid-operation clears everything immediately, asynchronously; in-flight messages are lost.

## Configuration
- CORE_MAILBOX_OVF_STICKY_EN defined:
  - A dropped push sets the sender's overflow flag, which appears at STATUS bit2 on the sender's side.
  - The flag is sticky until a CTRL write with bit1=1 or reset.
  - A CTRL clear and a new overflow in the same cycle leave the flag set.
- Not defined:
  - No overflow flag registers are built.
  - STATUS bit2 reads 0 and CTRL bit1 is ignored.

## Structure
- Package core_mailbox_pkg:
  - Offsets: MBOX_DATA=2'd0, MBOX_STATUS=2'd1, MBOX_CTRL=2'd2.
  - STATUS bit positions and CTRL bit positions.
- One sub-module, mbox_fifo, instantiated twice:
  - Synchronous-write circular buffer with push, pop and flush inputs.
  - Provides head data, count, full and empty.
  - Handles all same-cycle push/pop/flush resolution internally.
- The top level holds address decode, read muxing and the optional overflow flags.

## Test plan
- Reset, then core 0 stores 0x11, 0x22, 0x33 to BASE+0 → irq1=1; core 1 reads STATUS = 0x0000_0301; three core 1 DATA loads return 0x11, 0x22, 0x33; then irq1=0.
- Core 1 pushes 9 words into a DEPTH=8 FIFO → STATUS bit1=1 after the 8th push; the 9th is dropped; with the macro, core 1 STATUS bit2=1; core 0 reads 1..8 in order and the 9th value never appears.
- FIFO holding 3 words; core 0 pushes while core 1 pops in the same cycle → count stays 3; order preserved across pointer wrap after 20 such cycles.
- FIFO holding 5 words; core 1 writes CTRL=1 while core 0 pushes → count 0; irq1=0; subsequent DATA load returns 0.
- Empty FIFO; core 1 loads DATA with re1=1 → rdata1=0; count stays 0; no underflow. addr1=BASE+0x100 → hit1=0 and rdata1=0.
- Reset asserted between edges with 4 words queued → irq0/irq1 drop without waiting for a clock edge; STATUS reads 0 after release.
